rdback_serializer: RTL and testbench

RDBACK_SERIALIZER -- requirements
Module: rdback_serializer

---
 rtl/rdback_serializer.sv | 108 ++++++++++
 tb/tb_rdback_serializer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rdback_serializer.sv
// Readback serializer: pulls IN_WIDTH words from a readback FIFO and streams
// them to the host as NBEATS valid/ready beats of OUT_WIDTH bits, LSB slice first.
module rdback_serializer #(
  parameter int IN_WIDTH  = 512,
  parameter int OUT_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdback_fifo_empty,
  output logic                 rdback_fifo_rden,
  input  logic [IN_WIDTH-1:0]  rdback_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [OUT_WIDTH-1:0] tx_data,
  output logic                 tx_last,
  input  logic                 cnt_clear,
  output logic [15:0]          words_sent
);

  localparam int NBEATS = IN_WIDTH / OUT_WIDTH;
  localparam int IDX_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBEATS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     idx, idx_nxt;
  logic [IN_WIDTH-1:0]  holding;
  logic                 load_en;
  logic                 rden_c;
  logic                 last_beat;
  logic                 xfer;

  assign tx_valid  = (state == STREAM);
  assign last_beat = (idx == LAST_IDX);
  assign tx_last   = tx_valid & last_beat;
  assign xfer      = tx_valid & tx_ready;
  assign tx_data   = holding[idx*OUT_WIDTH +: OUT_WIDTH];

  // The read strobe is combinational, so gate it with reset to keep the FIFO
  // untouched while rst is held even though state already reads IDLE.
  assign rdback_fifo_rden = rden_c & ~rst;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    rden_c    = 1'b0;
    load_en   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rdback_fifo_empty) begin
          rden_c    = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        load_en   = 1'b1;
        idx_nxt   = '0;
        state_nxt = STREAM;
      end
      STREAM: begin
        if (xfer) begin
          if (!last_beat) begin
            idx_nxt = idx + IDX_W'(1);
          end else if (!rdback_fifo_empty) begin
            rden_c    = 1'b1;
            state_nxt = LOAD;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      holding <= '0;
    end else if (load_en) begin
      holding <= rdback_data;
    end
  end

  // Updated every cycle; clear wins over the completion of a word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      words_sent <= '0;
    end else begin
      words_sent <= cnt_clear ? 16'h0000 : words_sent + {15'd0, xfer & last_beat};
    end
  end

endmodule

// File: tb/tb_rdback_serializer.sv
// Directed bench for rdback_serializer with a behavioural FIFO and beat monitor.
module tb_rdback_serializer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rdback_fifo_empty = 1'b1;
  logic         rdback_fifo_rden;
  logic [511:0] rdback_data = '0;
  logic         tx_valid;
  logic         tx_ready = 1'b0;
  logic [63:0]  tx_data;
  logic         tx_last;
  logic         cnt_clear = 1'b0;
  logic [15:0]  words_sent;

  int checks = 0;
  int errors = 0;

  logic [511:0] fifo_q[$];
  logic [511:0] pend;
  logic         have_pend = 1'b0;
  logic         clr_on_last = 1'b0;

  int           cyc;
  int           rden_cyc[$];
  int           beat_cyc[$];
  logic [63:0]  beat_data[$];
  logic         beat_last[$];

  logic         s_valid, s_last, s_rden;
  logic [63:0]  s_data;

  rdback_serializer dut (
    .clk               (clk),
    .rst               (rst),
    .rdback_fifo_empty (rdback_fifo_empty),
    .rdback_fifo_rden  (rdback_fifo_rden),
    .rdback_data       (rdback_data),
    .tx_valid          (tx_valid),
    .tx_ready          (tx_ready),
    .tx_data           (tx_data),
    .tx_last           (tx_last),
    .cnt_clear         (cnt_clear),
    .words_sent        (words_sent)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] slice_of(input logic [7:0] base, input int k);
    logic [7:0] b;
    b = base + 8'(k);
    return {8{b}};
  endfunction

  function automatic logic [511:0] make_word(input logic [7:0] base);
    logic [511:0] w;
    for (int k = 0; k < 8; k++) w[k*64 +: 64] = slice_of(base, k);
    return w;
  endfunction

  task automatic clear_mon();
    cyc = 0;
    rden_cyc.delete();
    beat_cyc.delete();
    beat_data.delete();
    beat_last.delete();
  endtask

  // One clock: drive at negedge, sample shortly after, serve the FIFO read.
  task automatic step();
    @(negedge clk);
    rdback_fifo_empty = (fifo_q.size() == 0);
    #1;
    s_valid = tx_valid;
    s_data  = tx_data;
    s_last  = tx_last;
    s_rden  = rdback_fifo_rden;
    if (rdback_fifo_rden === 1'b1 && fifo_q.size() > 0) begin
      rden_cyc.push_back(cyc);
      pend      = fifo_q.pop_front();
      have_pend = 1'b1;
    end
    if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
      beat_cyc.push_back(cyc);
      beat_data.push_back(tx_data);
      beat_last.push_back(tx_last);
    end
    if (clr_on_last) cnt_clear = tx_valid & tx_ready & tx_last;
    @(posedge clk);
    #1;
    if (have_pend) begin
      rdback_data = pend;
      have_pend   = 1'b0;
    end
    if (clr_on_last) cnt_clear = 1'b0;
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rdback_fifo_empty = 1'b0;
    tx_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rdback_fifo_rden !== 1'b0) begin errors++; $display("FAIL reset_rden got %b want 0", rdback_fifo_rden); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", tx_valid); end
    checks++; if (tx_last !== 1'b0) begin errors++; $display("FAIL reset_last got %b want 0", tx_last); end
    checks++; if (tx_data !== 64'h0) begin errors++; $display("FAIL reset_data got %h want 0", tx_data); end
    checks++; if (words_sent !== 16'h0) begin errors++; $display("FAIL reset_words got %h want 0", words_sent); end
    rdback_fifo_empty = 1'b1;
    rst = 1'b0;
  endtask

  task automatic test_idle();
    int bad;
    bad = 0;
    clear_mon();
    for (int i = 0; i < 100; i++) begin
      step();
      checks++;
      if (s_rden !== 1'b0 || s_valid !== 1'b0) begin
        errors++;
        $display("FAIL idle_quiet cycle %0d rden %b valid %b want 0 0", i, s_rden, s_valid);
      end
    end
  endtask

  task automatic test_single();
    clear_mon();
    tx_ready = 1'b1;
    fifo_q.push_back(make_word(8'h00));
    repeat (14) step();
    checks++; if (rden_cyc.size() !== 1) begin errors++; $display("FAIL single_rden_count got %0d want 1", rden_cyc.size()); end
    checks++; if (beat_data.size() !== 8) begin errors++; $display("FAIL single_beats got %0d want 8", beat_data.size()); end
    if (rden_cyc.size() > 0 && beat_cyc.size() > 0) begin
      checks++;
      if (beat_cyc[0] !== rden_cyc[0] + 2) begin
        errors++; $display("FAIL single_latency first beat cycle %0d want %0d", beat_cyc[0], rden_cyc[0] + 2);
      end
    end
    for (int k = 0; k < 8; k++) begin
      if (k < beat_data.size()) begin
        checks++;
        if (beat_data[k] !== slice_of(8'h00, k) || beat_last[k] !== (k == 7) ||
            beat_cyc[k] !== beat_cyc[0] + k) begin
          errors++;
          $display("FAIL single_beat%0d got %h last %b cyc %0d want %h last %b cyc %0d",
                   k, beat_data[k], beat_last[k], beat_cyc[k], slice_of(8'h00, k), (k == 7), beat_cyc[0] + k);
        end
      end
    end
    checks++; if (words_sent !== 16'd1) begin errors++; $display("FAIL single_words got %0d want 1", words_sent); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bases [3];
    bases[0] = 8'h10; bases[1] = 8'h20; bases[2] = 8'h30;
    tx_ready  = 1'b1;
    cnt_clear = 1'b1;
    step();
    cnt_clear = 1'b0;
    checks++; if (words_sent !== 16'd0) begin errors++; $display("FAIL b2b_clear got %0d want 0", words_sent); end
    clear_mon();
    for (int w = 0; w < 3; w++) fifo_q.push_back(make_word(bases[w]));
    repeat (34) step();
    checks++; if (rden_cyc.size() !== 3) begin errors++; $display("FAIL b2b_rden_count got %0d want 3", rden_cyc.size()); end
    checks++; if (beat_data.size() !== 24) begin errors++; $display("FAIL b2b_beats got %0d want 24", beat_data.size()); end
    for (int k = 0; k < 24; k++) begin
      if (k < beat_data.size()) begin
        checks++;
        if (beat_data[k] !== slice_of(bases[k/8], k % 8) || beat_last[k] !== ((k % 8) == 7)) begin
          errors++;
          $display("FAIL b2b_beat%0d got %h last %b want %h last %b",
                   k, beat_data[k], beat_last[k], slice_of(bases[k/8], k % 8), ((k % 8) == 7));
        end
      end
    end
    for (int w = 1; w < 3; w++) begin
      if (w < rden_cyc.size() && w*8 - 1 < beat_cyc.size()) begin
        checks++;
        if (rden_cyc[w] !== beat_cyc[w*8 - 1]) begin
          errors++; $display("FAIL b2b_rden%0d at cycle %0d want %0d", w, rden_cyc[w], beat_cyc[w*8 - 1]);
        end
      end
    end
    checks++; if (words_sent !== 16'd3) begin errors++; $display("FAIL b2b_words got %0d want 3", words_sent); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle_valid got %b want 0", tx_valid); end
  endtask

  task automatic test_stall();
    logic        stalled;
    logic [63:0] pdata;
    logic        plast;
    stalled = 1'b0;
    pdata   = '0;
    plast   = 1'b0;
    clear_mon();
    fifo_q.push_back(make_word(8'hA0));
    for (int i = 0; i < 40; i++) begin
      tx_ready = ((i % 4) == 0) || ((i % 4) == 3);
      step();
      if (stalled) begin
        checks++;
        if (s_valid !== 1'b1 || s_data !== pdata || s_last !== plast) begin
          errors++;
          $display("FAIL stall_hold cycle %0d valid %b data %h last %b want 1 %h %b", i, s_valid, s_data, s_last, pdata, plast);
        end
      end
      stalled = s_valid & ~tx_ready;
      pdata   = s_data;
      plast   = s_last;
    end
    tx_ready = 1'b1;
    checks++; if (beat_data.size() !== 8) begin errors++; $display("FAIL stall_beats got %0d want 8", beat_data.size()); end
    for (int k = 0; k < 8; k++) begin
      if (k < beat_data.size()) begin
        checks++;
        if (beat_data[k] !== slice_of(8'hA0, k) || beat_last[k] !== (k == 7)) begin
          errors++;
          $display("FAIL stall_beat%0d got %h last %b want %h last %b", k, beat_data[k], beat_last[k], slice_of(8'hA0, k), (k == 7));
        end
      end
    end
    checks++; if (words_sent !== 16'd4) begin errors++; $display("FAIL stall_words got %0d want 4", words_sent); end
  endtask

  task automatic test_reset_mid();
    int guard;
    clear_mon();
    tx_ready = 1'b1;
    fifo_q.push_back(make_word(8'h40));
    fifo_q.push_back(make_word(8'h50));
    guard = 0;
    while (beat_data.size() < 4 && guard < 20) begin
      step();
      guard++;
    end
    checks++; if (beat_data.size() !== 4) begin errors++; $display("FAIL rstmid_reach got %0d beats want 4", beat_data.size()); end
    rst = 1'b1;
    #1;
    checks++; if (tx_valid !== 1'b0 || tx_last !== 1'b0) begin errors++; $display("FAIL rstmid_ctrl valid %b last %b want 0 0", tx_valid, tx_last); end
    checks++; if (tx_data !== 64'h0) begin errors++; $display("FAIL rstmid_data got %h want 0", tx_data); end
    checks++; if (rdback_fifo_rden !== 1'b0) begin errors++; $display("FAIL rstmid_rden got %b want 0", rdback_fifo_rden); end
    checks++; if (words_sent !== 16'd0) begin errors++; $display("FAIL rstmid_words got %0d want 0", words_sent); end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (s_rden !== 1'b0 || s_valid !== 1'b0) begin
        errors++; $display("FAIL rstmid_held rden %b valid %b want 0 0", s_rden, s_valid);
      end
    end
    clear_mon();
    rst = 1'b0;
    repeat (14) step();
    checks++; if (rden_cyc.size() !== 1) begin errors++; $display("FAIL rstmid_rden_count got %0d want 1", rden_cyc.size()); end
    checks++; if (beat_data.size() !== 8) begin errors++; $display("FAIL rstmid_beats got %0d want 8", beat_data.size()); end
    for (int k = 0; k < 8; k++) begin
      if (k < beat_data.size()) begin
        checks++;
        if (beat_data[k] !== slice_of(8'h50, k) || beat_last[k] !== (k == 7)) begin
          errors++;
          $display("FAIL rstmid_beat%0d got %h last %b want %h last %b", k, beat_data[k], beat_last[k], slice_of(8'h50, k), (k == 7));
        end
      end
    end
    checks++; if (words_sent !== 16'd1) begin errors++; $display("FAIL rstmid_words_after got %0d want 1", words_sent); end
  endtask

  task automatic test_wrap_and_clear();
    tx_ready = 1'b1;
    force dut.words_sent = 16'hFFFF;
    #1;
    release dut.words_sent;
    clear_mon();
    fifo_q.push_back(make_word(8'h60));
    repeat (14) step();
    checks++; if (beat_data.size() !== 8) begin errors++; $display("FAIL wrap_beats got %0d want 8", beat_data.size()); end
    checks++; if (words_sent !== 16'h0000) begin errors++; $display("FAIL wrap_words got %h want 0000", words_sent); end
    clr_on_last = 1'b1;
    fifo_q.push_back(make_word(8'h70));
    repeat (14) step();
    clr_on_last = 1'b0;
    checks++; if (words_sent !== 16'h0000) begin errors++; $display("FAIL clear_priority got %h want 0000", words_sent); end
    fifo_q.push_back(make_word(8'h80));
    repeat (14) step();
    checks++; if (words_sent !== 16'h0001) begin errors++; $display("FAIL count_after_clear got %h want 0001", words_sent); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_wrap_and_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
